// File: rtl/fifo_read_stream_adapter.sv
// Reader-side adapter for a FIFO with registered data-valid return.
// It issues FIFO reads only when every returning word is guaranteed a slot
// in a local skid buffer. It also presents the buffered words downstream as a
// show-ahead valid/ready stream.
//
// Ports:
//   clk_i            sole clock (FIFO read clock)
//   rst_i            synchronous active-high reset (also clears the FIFO)
//   enable_i         permits new reads; in-flight reads still complete
//   fifoReadEnable_o FIFO readEnable (combinational from registered state)
//   fifoDataValid_i  FIFO dataOutValid
//   fifoData_i       FIFO dataOut
//   outValid_o       downstream valid (buffer non-empty)
//   outReady_i       downstream accept
//   outData_o        downstream data, head of the buffer
//   occupancy_o      number of words held in the buffer
//   protocolError_o  sticky error: unexpected or unstorable return word
module fifo_read_stream_adapter #(
    parameter int unsigned WIDTH          = 160,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned BUF_DEPTH_LOG2 = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    output logic                      fifoReadEnable_o,
    input  logic                      fifoDataValid_i,
    input  logic [WIDTH-1:0]          fifoData_i,
    output logic                      outValid_o,
    input  logic                      outReady_i,
    output logic [WIDTH-1:0]          outData_o,
    output logic [BUF_DEPTH_LOG2:0]   occupancy_o,
    output logic                      protocolError_o
);

    localparam int unsigned DEPTH = 1 << BUF_DEPTH_LOG2;
    localparam int unsigned OCC_W = BUF_DEPTH_LOG2 + 1;
    localparam int unsigned PTR_W = BUF_DEPTH_LOG2;
    // Headroom for occupancy plus a popcount of up to 8 in-flight reads.
    localparam int unsigned SUM_W = OCC_W + 4;

    logic [READ_LATENCY-1:0] issue_q, issue_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
    logic                    err_q, err_d;
    logic                    rst_dly_q;
    logic [WIDTH-1:0]        mem [DEPTH];

    logic [SUM_W-1:0]        reserved;
    logic                    issue;
    logic                    tail;
    logic                    full;
    logic                    push;
    logic                    pop;

    // Reads in flight, each holding a reserved buffer slot.
    always_comb begin
        reserved = '0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            reserved = reserved + SUM_W'(issue_q[i]);
        end
    end

    // Issue only if buffered words plus outstanding reservations leave a free
    // slot. This is also held off on the cycle after reset so that the FIFO
    // clear settles.
    assign issue = enable_i & ~rst_i & ~rst_dly_q
                 & ((SUM_W'(occ_q) + reserved) < SUM_W'(DEPTH));

    // Next-state: issue pipe shift, buffer push/pop, sticky error.
    always_comb begin
        issue_d  = '0;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        err_d    = err_q;

        issue_d[0] = issue;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            issue_d[i] = issue_q[i-1];
        end

        tail = issue_q[READ_LATENCY-1];
        full = (occ_q == OCC_W'(DEPTH));
        pop  = (occ_q != '0) & outReady_i;
        push = fifoDataValid_i & tail & ~full;

        // Any return that is not matched by a reservation, or that finds no
        // room, is dropped and flagged.
        if (fifoDataValid_i & ~(tail & ~full)) begin
            err_d = 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push & ~pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop & ~push) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issue_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            occ_q     <= '0;
            err_q     <= 1'b0;
            rst_dly_q <= 1'b1;
        end else begin
            issue_q   <= issue_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            occ_q     <= occ_d;
            err_q     <= err_d;
            rst_dly_q <= 1'b0;
        end
    end

    // Skid buffer storage; contents are don't-care while empty.
    always_ff @(posedge clk_i) begin
        if (push & ~rst_i) begin
            mem[wr_ptr_q] <= fifoData_i;
        end
    end

    assign fifoReadEnable_o = issue;
    assign outValid_o       = (occ_q != '0);
    assign outData_o        = mem[rd_ptr_q];
    assign occupancy_o      = occ_q;
    assign protocolError_o  = err_q;

endmodule

// File: tb/tb_fifo_read_stream_adapter.sv
// Directed bench for fifo_read_stream_adapter. It uses two instances: the
// default configuration and a long-latency one (READ_LATENCY=4, 8 entries).
// Each instance is paired with a small FIFO model that returns word(base+n)
// READ_LATENCY cycles after each accepted read.
module tb_fifo_read_stream_adapter;

    localparam int unsigned W  = 160;
    localparam int unsigned LA = 1;
    localparam int unsigned LB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    function automatic logic [W-1:0] word(input int unsigned k);
        return {k, 64'hDEAD_BEEF_0BAD_F00D, ~k, 32'(k * 7)};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- instance A: defaults ----------------
    logic             rst_a = 1'b1, en_a = 1'b0, ordy_a = 1'b0, spur_a = 1'b0;
    logic             fre_a, fdv_a, ov_a, perr_a;
    logic [W-1:0]     fd_a, od_a;
    logic [2:0]       occ_a;
    logic             ma_clr = 1'b1;
    int unsigned      ma_total = 0, ma_base = 0, ma_rd;
    logic [LA-1:0]    ma_v;
    logic [W-1:0]     ma_d [LA];

    fifo_read_stream_adapter u_dut_a (
        .clk_i(clk), .rst_i(rst_a), .enable_i(en_a),
        .fifoReadEnable_o(fre_a), .fifoDataValid_i(fdv_a), .fifoData_i(fd_a),
        .outValid_o(ov_a), .outReady_i(ordy_a), .outData_o(od_a),
        .occupancy_o(occ_a), .protocolError_o(perr_a)
    );

    always @(posedge clk) begin
        if (rst_a) begin
            ma_v <= '0;
        end else begin
            ma_v[0] <= fre_a && (ma_rd < ma_total);
            ma_d[0] <= word(ma_base + ma_rd);
            for (int i = 1; i < int'(LA); i++) begin
                ma_v[i] <= ma_v[i-1];
                ma_d[i] <= ma_d[i-1];
            end
        end
        if (ma_clr) ma_rd <= 0;
        else if (!rst_a && fre_a && ma_rd < ma_total) ma_rd <= ma_rd + 1;
    end
    assign fdv_a = ma_v[LA-1] | spur_a;
    assign fd_a  = ma_d[LA-1];

    // ---------------- instance B: long latency ----------------
    logic             rst_b = 1'b1, en_b = 1'b0, ordy_b = 1'b0;
    logic             fre_b, fdv_b, ov_b, perr_b;
    logic [W-1:0]     fd_b, od_b;
    logic [3:0]       occ_b;
    logic             mb_clr = 1'b1;
    int unsigned      mb_total = 0, mb_base = 0, mb_rd;
    logic [LB-1:0]    mb_v;
    logic [W-1:0]     mb_d [LB];

    fifo_read_stream_adapter #(.WIDTH(W), .READ_LATENCY(LB), .BUF_DEPTH_LOG2(3)) u_dut_b (
        .clk_i(clk), .rst_i(rst_b), .enable_i(en_b),
        .fifoReadEnable_o(fre_b), .fifoDataValid_i(fdv_b), .fifoData_i(fd_b),
        .outValid_o(ov_b), .outReady_i(ordy_b), .outData_o(od_b),
        .occupancy_o(occ_b), .protocolError_o(perr_b)
    );

    always @(posedge clk) begin
        if (rst_b) begin
            mb_v <= '0;
        end else begin
            mb_v[0] <= fre_b && (mb_rd < mb_total);
            mb_d[0] <= word(mb_base + mb_rd);
            for (int i = 1; i < int'(LB); i++) begin
                mb_v[i] <= mb_v[i-1];
                mb_d[i] <= mb_d[i-1];
            end
        end
        if (mb_clr) mb_rd <= 0;
        else if (!rst_b && fre_b && mb_rd < mb_total) mb_rd <= mb_rd + 1;
    end
    assign fdv_b = mb_v[LB-1];
    assign fd_b  = mb_d[LB-1];

    // Reset A with a freshly loaded FIFO model; returns on the first cycle
    // after reset, which must still hold issue off.
    task automatic reset_a(input int unsigned total, input int unsigned base);
        rst_a = 1'b1; ma_clr = 1'b1; ma_total = total; ma_base = base;
        step(); step();
        check("rst_fre",  W'(fre_a),  W'(0));
        check("rst_ov",   W'(ov_a),   W'(0));
        check("rst_occ",  W'(occ_a),  W'(0));
        check("rst_perr", W'(perr_a), W'(0));
        rst_a = 1'b0; ma_clr = 1'b0;
        check("post_rst_fre", W'(fre_a), W'(0));
    endtask

    int unsigned idx;

    initial begin
        @(negedge clk);

        // Basic transfer: 3 words, outReady high.
        en_a = 1'b1; ordy_a = 1'b1;
        reset_a(3, 0);
        step();  // c0
        check("basic_fre_c0", W'(fre_a), W'(1));
        check("basic_ov_c0",  W'(ov_a),  W'(0));
        step();  // c1
        check("basic_ov_c1",  W'(ov_a),  W'(0));
        check("basic_occ_c1", W'(occ_a), W'(0));
        step();  // c2
        check("basic_ov_c2",  W'(ov_a),  W'(1));
        check("basic_d0",     od_a,      word(0));
        check("basic_occ_c2", W'(occ_a), W'(1));
        step();
        check("basic_d1",     od_a,      word(1));
        check("basic_occ_c3", W'(occ_a), W'(1));
        step();
        check("basic_d2",     od_a,      word(2));
        step();  // c5
        check("basic_ov_c5",  W'(ov_a),  W'(0));
        check("basic_occ_c5", W'(occ_a), W'(0));
        check("basic_fre_c5", W'(fre_a), W'(1));
        check("basic_perr",   W'(perr_a), W'(0));

        // Backpressure fill: 10 words, outReady low until the buffer fills.
        ordy_a = 1'b0;
        reset_a(10, 100);
        for (int c = 0; c < 8; c++) step();
        check("bp_occ_full", W'(occ_a), W'(4));
        check("bp_fre_off",  W'(fre_a), W'(0));
        check("bp_ov",       W'(ov_a),  W'(1));
        check("bp_head",     od_a,      word(100));
        ordy_a = 1'b1;
        idx = 0;
        for (int c = 0; c < 60 && idx < 10; c++) begin
            if (ov_a) begin
                check("bp_data", od_a, word(100 + idx));
                idx++;
            end
            step();
        end
        check("bp_count", W'(idx), W'(10));
        check("bp_perr",  W'(perr_a), W'(0));

        // Pointer wrap with outReady toggling: 40 words through 4 entries.
        reset_a(40, 500);
        idx = 0;
        for (int c = 0; c < 300 && idx < 40; c++) begin
            ordy_a = c[0];
            if (ov_a && ordy_a) begin
                check("wrap_data", od_a, word(500 + idx));
                idx++;
            end
            step();
        end
        check("wrap_count", W'(idx), W'(40));
        check("wrap_perr",  W'(perr_a), W'(0));

        // Spurious return with the issue pipe empty (enable low).
        en_a = 1'b0; ordy_a = 1'b1;
        reset_a(0, 0);
        step(); step();
        check("spur_fre_off", W'(fre_a), W'(0));
        spur_a = 1'b1;
        step();
        spur_a = 1'b0;
        check("spur_perr",  W'(perr_a), W'(1));
        check("spur_occ",   W'(occ_a),  W'(0));
        check("spur_ov",    W'(ov_a),   W'(0));
        step(); step(); step();
        check("spur_sticky", W'(perr_a), W'(1));
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        check("spur_rst_clear", W'(perr_a), W'(0));

        // Mid-stream reset with occupancy 3 and one read returning.
        en_a = 1'b1; ordy_a = 1'b0;
        reset_a(10, 200);
        for (int c = 0; c < 5; c++) step();  // c4
        check("mid_occ3", W'(occ_a), W'(3));
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        check("mid_ov",  W'(ov_a),   W'(0));
        check("mid_occ", W'(occ_a),  W'(0));
        check("mid_fre", W'(fre_a),  W'(0));
        step();
        check("mid_resume", W'(fre_a), W'(1));
        check("mid_perr",   W'(perr_a), W'(0));
        en_a = 1'b0;

        // Long latency: 20 words, READ_LATENCY=4, 8 entries.
        en_b = 1'b1; ordy_b = 1'b1;
        rst_b = 1'b1; mb_clr = 1'b1; mb_total = 20; mb_base = 1000;
        step(); step();
        check("ll_rst_ov", W'(ov_b), W'(0));
        rst_b = 1'b0; mb_clr = 1'b0;
        check("ll_post_rst_fre", W'(fre_b), W'(0));
        step();  // c0
        check("ll_fre_c0", W'(fre_b), W'(1));
        for (int c = 0; c < 5; c++) begin
            check("ll_startup_ov", W'(ov_b), W'(0));
            step();
        end
        for (int k = 0; k < 20; k++) begin
            check("ll_ov",   W'(ov_b), W'(1));
            check("ll_data", od_b,     word(1000 + k));
            step();
        end
        check("ll_ov_end", W'(ov_b),   W'(0));
        check("ll_perr",   W'(perr_b), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_read_stream_adapter.md
Name: fifo_read_stream_adapter

Overview:
- Single-clock reader-side companion to dualClockFIFOWithDataValid.
- Drives the FIFO's readEnable and absorbs its dataOutValid/dataOut return into a small local skid buffer.
- Presents the data downstream as a valid/ready stream with backpressure.
- Issues reads only when buffer space is guaranteed, so no returned word is ever dropped.

Parameters:
- WIDTH, 160, data word width; matches the FIFO WIDTH.
- READ_LATENCY, 1, cycles from fifoReadEnable high to the corresponding fifoDataValid; legal range 1..8.
- BUF_DEPTH_LOG2, 2, log2 of local skid buffer entries (default 4 entries).

Ports:
- clk  in  1  Sole clock; same as the FIFO rdclk.
- rst  in  1  Synchronous, active-high reset; the same signal drives the FIFO rdclr.
- enable  in  1  Permits issuing new reads; in-flight reads still complete when low.
- fifoReadEnable  out  1  To FIFO readEnable.
- fifoDataValid  in  1  From FIFO dataOutValid.
- fifoData  in  WIDTH  From FIFO dataOut.
- outValid  out  1  Downstream data valid.
- outReady  in  1  Downstream accept.
- outData  out  WIDTH  Downstream data, the head of the buffer.
- occupancy  out  BUF_DEPTH_LOG2+1  Number of words held in the buffer.
- protocolError  out  1  Sticky error flag.

Behaviour:
- Reset state while rst is high and on the cycle after: fifoReadEnable=0, outValid=0, occupancy=0, protocolError=0.
  - Issue pipe and buffer pointers cleared; outData is don't-care.
- Issue pipe: READ_LATENCY-bit shift register.
  - Bit 0 is loaded with fifoReadEnable every cycle.
  - The tail bit marks the cycle in which the FIFO may return a word for that request.
  - reserved = popcount of the shift register.
- fifoReadEnable = enable & !rst & (occupancy + reserved < 2^BUF_DEPTH_LOG2). This is combinational from registered state only.
  - A read issued while the FIFO is empty returns no word. Its reservation is released when its tail bit shifts out.
- Return handling:
  - fifoDataValid=1 with the tail bit set: fifoData is written into the buffer at the end of that cycle.
  - fifoDataValid=1 with the tail bit clear: the word is dropped and protocolError is set. It stays set until rst.
- Buffer: circular, 2^BUF_DEPTH_LOG2 entries; read and write pointers of BUF_DEPTH_LOG2 bits with unsigned wrap.
  - outValid = (occupancy != 0). outData = mem[rdPtr], show-ahead.
  - Pop when outValid & outReady.
  - Push and pop in the same cycle: occupancy unchanged, both pointers advance.
  - Push into an empty buffer: outValid rises on the next cycle (return-to-output latency of 1).
  - outValid and outData are held stable while outReady=0.
- Overflow is impossible by construction. If a push is ever attempted at full occupancy, the word is dropped and protocolError is set.
- Throughput: with a non-empty FIFO and outReady held high, one word per cycle is sustained when 2^BUF_DEPTH_LOG2 >= READ_LATENCY+2.
- Reset mid-operation: in-flight reservations and buffered words are discarded.
  - The FIFO is cleared by the same rst, so no stale fifoDataValid arrives afterwards.
  - A stale fifoDataValid, if it does arrive, raises protocolError.
- enable deasserted: no new issues; outstanding returns are still accepted and drained.

Test Plan:
- Basic transfer: defaults; FIFO model holds 3 words A, B, C; outReady=1.
  - fifoReadEnable is high for 3 cycles, then held high against an empty FIFO.
  - outData is A, B, C on consecutive outValid cycles; occupancy never exceeds 2; protocolError=0.
- Backpressure fill: defaults; FIFO holds 10 words; outReady=0.
  - Issue stops once occupancy+reserved=4; occupancy settles at 4 and fifoReadEnable=0.
  - Release outReady: all 10 words are delivered in order with no loss.
- Long latency: READ_LATENCY=4, BUF_DEPTH_LOG2=3; FIFO holds 20 words; outReady=1.
  - After a 5-cycle startup, outValid stays continuously high for 20 cycles.
- Pointer wrap with simultaneous push/pop: outReady toggles 1,0,1,0 over 40 words.
  - Pointers wrap at least 5 times; the data sequence is exact.
- Spurious return: pulse fifoDataValid with an empty issue pipe.
  - protocolError=1 from the next cycle and stays set; buffer unchanged.
  - rst clears protocolError.
- Mid-stream reset: assert rst for 1 cycle while occupancy=3 with 1 read in flight.
  - outValid=0 and occupancy=0 the cycle after rst.
  - Issuing resumes on the following cycle.
